// File: rtl/wb_host_bridge.sv
// rtl/wb_host_bridge.sv - Caravel Wishbone entry bridge with config registers and slave timeout
module wb_host_bridge #(
  parameter logic [23:0] CFG_BASE = 24'h3080_00,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
  input  logic        wbm_clk_i,
  input  logic        wbm_rst_n,
  input  logic        wbm_cyc_i,
  input  logic        wbm_stb_i,
  input  logic        wbm_we_i,
  input  logic [31:0] wbm_adr_i,
  input  logic [31:0] wbm_dat_i,
  input  logic [3:0]  wbm_sel_i,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_ack_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  output logic [6:0]  soft_rst_n_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_FWD  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  localparam logic [1:0] OFF_GLBL_CTRL = 2'd0;
  localparam logic [1:0] OFF_BANK_SEL  = 2'd1;
  localparam logic [1:0] OFF_STATUS    = 2'd2;
  localparam logic [1:0] OFF_SCRATCH   = 2'd3;

  state_t state;
  state_t state_nxt;

  // Config register bank
  logic [6:0]  glbl_ctrl;
  logic [7:0]  bank_sel;
  logic        sticky_to;
  logic        sticky_err;
  logic [7:0]  abort_cnt;
  logic [31:0] scratch;

  // Forwarded-access bookkeeping
  logic        lat_we;
  logic [31:0] lat_adr;
  logic [31:0] lat_dat;
  logic [3:0]  lat_sel;
  logic [15:0] fwd_cnt;
  logic        fwd_aborted;

  // Decoded request and FSM event strobes
  logic        req;
  logic        cfg_hit;
  logic        acc_cfg;
  logic        acc_fwd;
  logic        fwd_ack;
  logic        fwd_err;
  logic        fwd_to;
  logic        fwd_done;
  logic        upstream_gone;
  logic        cfg_wr;
  logic [1:0]  cfg_off;
  logic [31:0] cfg_rdata;
  logic [31:0] wr_mask;

  // Address bits below the word offset and above it inside the bank are don't-care
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wbm_adr_i[7:4], wbm_adr_i[1:0]};

  assign req           = wbm_cyc_i & wbm_stb_i & ~wbm_ack_o;
  assign cfg_hit       = (wbm_adr_i[31:8] == CFG_BASE);
  assign cfg_off       = wbm_adr_i[3:2];
  assign cfg_wr        = acc_cfg & wbm_we_i;
  assign fwd_done      = fwd_ack | fwd_err | fwd_to;
  assign upstream_gone = fwd_aborted | ~wbm_cyc_i;
  assign wr_mask       = {{8{wbm_sel_i[3]}}, {8{wbm_sel_i[2]}},
                          {8{wbm_sel_i[1]}}, {8{wbm_sel_i[0]}}};

  // Downstream controls follow the FSM; everything else comes from the latches
  assign wbs_cyc_o    = (state == ST_FWD);
  assign wbs_stb_o    = (state == ST_FWD);
  assign wbs_we_o     = lat_we;
  assign wbs_adr_o    = lat_adr;
  assign wbs_dat_o    = lat_dat;
  assign wbs_sel_o    = lat_sel;
  assign soft_rst_n_o = glbl_ctrl;

  // Register read mux; unimplemented bits read as zero
  always_comb begin
    cfg_rdata = 32'h0;
    case (cfg_off)
      OFF_GLBL_CTRL: cfg_rdata = {25'h0, glbl_ctrl};
      OFF_BANK_SEL:  cfg_rdata = {24'h0, bank_sel};
      OFF_STATUS:    cfg_rdata = {16'h0, abort_cnt, 6'h0, sticky_err, sticky_to};
      OFF_SCRATCH:   cfg_rdata = scratch;
      default:       cfg_rdata = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and event strobes; slave ack takes priority over error
  always_comb begin
    state_nxt = state;
    acc_cfg   = 1'b0;
    acc_fwd   = 1'b0;
    fwd_ack   = 1'b0;
    fwd_err   = 1'b0;
    fwd_to    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (cfg_hit) begin
            acc_cfg   = 1'b1;
            state_nxt = ST_CFG;
          end else begin
            acc_fwd   = 1'b1;
            state_nxt = ST_FWD;
          end
        end
      end
      ST_CFG: begin
        state_nxt = ST_IDLE;
      end
      ST_FWD: begin
        if (wbs_ack_i) begin
          fwd_ack = 1'b1;
        end else if (wbs_err_i) begin
          fwd_err = 1'b1;
        end else if (fwd_cnt == TIMEOUT_C) begin
          fwd_to = 1'b1;
        end
        if (wbs_ack_i || wbs_err_i || (fwd_cnt == TIMEOUT_C)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Upstream response: ack and data are held together for exactly one cycle
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      wbm_ack_o <= 1'b0;
      wbm_dat_o <= 32'h0;
    end else begin
      wbm_ack_o <= 1'b0;
      wbm_dat_o <= 32'h0;
      if (acc_cfg) begin
        wbm_ack_o <= 1'b1;
        wbm_dat_o <= cfg_rdata;
      end else if (fwd_done && !upstream_gone) begin
        wbm_ack_o <= 1'b1;
        wbm_dat_o <= fwd_ack ? wbs_dat_i : ERR_DATA;
      end
    end
  end

  // Latch the forwarded request; bank select is folded in here so later writes cannot move it
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      lat_we  <= 1'b0;
      lat_adr <= 32'h0;
      lat_dat <= 32'h0;
      lat_sel <= 4'h0;
    end else if (acc_fwd) begin
      lat_we  <= wbm_we_i;
      lat_adr <= {bank_sel, wbm_adr_i[23:0]};
      lat_dat <= wbm_dat_i;
      lat_sel <= wbm_sel_i;
    end
  end

  // Slave wait counter and upstream-abort tracking for the access in flight
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      fwd_cnt     <= 16'h0;
      fwd_aborted <= 1'b0;
    end else if (acc_fwd) begin
      fwd_cnt     <= 16'h0;
      fwd_aborted <= 1'b0;
    end else if (state == ST_FWD) begin
      fwd_cnt <= fwd_cnt + 16'd1;
      if (!wbm_cyc_i) begin
        fwd_aborted <= 1'b1;
      end
    end
  end

  // Control registers: soft resets, bank select, scratch; byte lanes honoured
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      glbl_ctrl <= 7'h0;
      bank_sel  <= 8'h0;
      scratch   <= 32'h0;
    end else if (cfg_wr) begin
      case (cfg_off)
        OFF_GLBL_CTRL: if (wbm_sel_i[0]) glbl_ctrl <= wbm_dat_i[6:0];
        OFF_BANK_SEL:  if (wbm_sel_i[0]) bank_sel <= wbm_dat_i[7:0];
        OFF_SCRATCH:   scratch <= (scratch & ~wr_mask) | (wbm_dat_i & wr_mask);
        default:       ;
      endcase
    end
  end

  // Status: sticky abort causes (write-one-to-clear) and a saturating abort counter
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      sticky_to  <= 1'b0;
      sticky_err <= 1'b0;
      abort_cnt  <= 8'h0;
    end else begin
      if (cfg_wr && (cfg_off == OFF_STATUS) && wbm_sel_i[0]) begin
        if (wbm_dat_i[0]) sticky_to <= 1'b0;
        if (wbm_dat_i[1]) sticky_err <= 1'b0;
      end
      if (fwd_to) sticky_to <= 1'b1;
      if (fwd_err) sticky_err <= 1'b1;
      if ((fwd_to || fwd_err) && (abort_cnt != 8'hFF)) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_host_bridge.sv
// tb/tb_wb_host_bridge.sv - randomized self-checking bench for wb_host_bridge
module tb_wb_host_bridge;

  localparam int TO = 15;
  localparam logic [31:0] ERRD = 32'hDEAD_DEAD;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i, wbs_err_i;
  logic [6:0]  soft_rst_n_o;

  int vectors = 0;
  int miscompares = 0;

  // Slave behaviour: 0 ack, 1 never respond, 2 err, 3 ack+err together
  int          slv_mode = 0;
  int          slv_delay = 1;
  logic [31:0] slv_rdata = 32'h0;
  int          wait_cnt = 0;
  int          last_cycles = 0;
  bit          responded = 0;
  logic [31:0] cap_adr = 0, cap_dat = 0;
  logic [3:0]  cap_sel = 0;
  logic        cap_we = 0;
  logic [6:0]  soft_snap;

  // Reference model of the register bank
  logic [6:0]  m_ctrl;
  logic [7:0]  m_bank;
  logic        m_to, m_err;
  int          m_cnt;
  logic [31:0] m_scr;

  wb_host_bridge #(.TIMEOUT(TO)) dut (
    .wbm_clk_i(clk), .wbm_rst_n(rst_n),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_we_i(we),
    .wbm_adr_i(adr), .wbm_dat_i(wdat), .wbm_sel_i(sel),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .soft_rst_n_o(soft_rst_n_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Downstream slave responder, driven on falling edges
  initial begin
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_dat_i = $urandom;
      if (!rst_n || !wbs_cyc_o) begin
        wait_cnt  = 0;
        responded = 0;
      end else if (wbs_stb_o) begin
        wait_cnt++;
        last_cycles = wait_cnt;
        cap_adr = wbs_adr_o;
        cap_dat = wbs_dat_o;
        cap_sel = wbs_sel_o;
        cap_we  = wbs_we_o;
        if (!responded && wait_cnt == slv_delay && slv_mode != 1) begin
          responded = 1;
          wbs_ack_i = (slv_mode == 0 || slv_mode == 3);
          wbs_err_i = (slv_mode == 2 || slv_mode == 3);
          wbs_dat_i = slv_rdata;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cfg_adr(input int off);
    logic [1:0] o;
    o = off[1:0];
    return {24'h3080_00, 4'h0, o, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input int off);
    case (off)
      0: return {25'h0, m_ctrl};
      1: return {24'h0, m_bank};
      2: return {16'h0, 8'(m_cnt), 6'h0, m_err, m_to};
      default: return m_scr;
    endcase
  endfunction

  task automatic m_write(input int off, input logic [31:0] d, input logic [3:0] s);
    case (off)
      0: if (s[0]) m_ctrl = d[6:0];
      1: if (s[0]) m_bank = d[7:0];
      2: if (s[0]) begin
           if (d[0]) m_to = 1'b0;
           if (d[1]) m_err = 1'b0;
         end
      default: for (int b = 0; b < 4; b++) if (s[b]) m_scr[8*b +: 8] = d[8*b +: 8];
    endcase
  endtask

  task automatic m_abort(input bit is_err);
    if (is_err) m_err = 1'b1; else m_to = 1'b1;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic m_reset();
    m_ctrl = 0; m_bank = 0; m_to = 0; m_err = 0; m_cnt = 0; m_scr = 0;
  endtask

  // One upstream transfer; reports data, latency in clocks and whether ack came
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
    bit got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got = 0; lat = 0; rd = 32'h0;
    for (int i = 1; i <= 64 && !got; i++) begin
      @(posedge clk); #1;
      if (wbm_ack_o) begin
        got = 1; lat = i; rd = wbm_dat_o; soft_snap = soft_rst_n_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    check("ack_single", 32'(wbm_ack_o), 32'd0);
    check("dat_zero_idle", wbm_dat_o, 32'h0);
  endtask

  task automatic cfg_write(input int off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, cfg_adr(off), d, s, rd, lat);
    m_write(off, d, s);
    check("cfg_wr_lat", 32'(lat), 32'd1);
    check("soft_rst_at_ack", 32'(soft_snap), 32'(m_ctrl));
  endtask

  task automatic cfg_read(input int off);
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b0, cfg_adr(off), $urandom, 4'hF, rd, lat);
    check("cfg_rd_lat", 32'(lat), 32'd1);
    check("cfg_rd_data", rd, m_read(off));
  endtask

  task automatic fwd(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int mode, input int delay, input logic [31:0] rdata);
    logic [31:0] rd;
    int lat;
    slv_mode = mode; slv_delay = delay; slv_rdata = rdata;
    wb_xfer(w, a, d, s, rd, lat);
    check("fwd_adr", cap_adr, {m_bank, a[23:0]});
    check("fwd_dat", cap_dat, d);
    check("fwd_sel", 32'(cap_sel), 32'(s));
    check("fwd_we", 32'(cap_we), 32'(w));
    if (mode == 1) begin
      check("to_lat", 32'(lat), 32'(TO + 2));
      check("to_stb_cycles", 32'(last_cycles), 32'(TO + 1));
      check("to_data", rd, ERRD);
      m_abort(1'b0);
    end else begin
      check("fwd_lat", 32'(lat), 32'(delay + 1));
      check("fwd_stb_cycles", 32'(last_cycles), 32'(delay));
      check("fwd_data", rd, (mode == 2) ? ERRD : rdata);
      if (mode == 2) m_abort(1'b1);
    end
  endtask

  function automatic logic [31:0] rand_slave_adr();
    logic [31:0] a;
    a = {8'h30, 1'b0, 7'($urandom), 16'($urandom)};
    a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    logic [31:0] a;
    int          md;
    bit          saw_ack;
    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
    soft_snap = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_soft", 32'(soft_rst_n_o), 32'h0);
    check("rst_ack", 32'(wbm_ack_o), 32'h0);
    check("rst_dat", wbm_dat_o, 32'h0);
    check("rst_wbs_cyc", 32'(wbs_cyc_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic register access and byte-lane masking
    cfg_read(0);
    cfg_write(0, 32'h0000_007F, 4'hF);
    check("soft_rst_7f", 32'(soft_rst_n_o), 32'h7F);
    cfg_read(0);
    cfg_write(0, 32'h0, 4'h0);
    check("soft_rst_sel0", 32'(soft_rst_n_o), 32'h7F);
    cfg_read(0);

    // Randomized register traffic
    for (int i = 0; i < 40; i++) begin
      md = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) cfg_write(md, $urandom, 4'($urandom));
      else cfg_read(md);
    end
    cfg_read(1);
    cfg_read(2);
    cfg_read(3);

    // Directed forward: bank remap, slave ack after 3 cycles, then a read
    cfg_write(1, 32'h10, 4'hF);
    fwd(1'b1, 32'h3000_0040, 32'h1234_5678, 4'hF, 0, 3, $urandom);
    check("fwd_remap_adr", cap_adr, 32'h1000_0040);
    fwd(1'b0, 32'h3000_0080, 32'h0, 4'hF, 0, 2, 32'hCAFE_F00D);

    // Timeout and W1C on the timeout flag
    cfg_write(2, 32'h3, 4'hF);
    fwd(1'b0, 32'h3000_0100, 32'h0, 4'hF, 1, 1, 32'h0);
    cfg_read(2);
    check("status_after_to", m_read(2), 32'h0000_0101);
    cfg_write(2, 32'h1, 4'hF);
    cfg_read(2);

    // ack+err together behaves as ack; err alone aborts
    fwd(1'b0, 32'h3000_0200, 32'h0, 4'hF, 3, 2, 32'h5555_AAAA);
    cfg_read(2);
    fwd(1'b0, 32'h3000_0204, 32'h0, 4'hF, 2, 2, 32'h0);
    cfg_read(2);

    // Randomized forwarded accesses against the model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(1, $urandom, 4'hF);
      md = $urandom_range(0, 2);
      md = (md == 0) ? 0 : (md == 1) ? 2 : 3;
      a = rand_slave_adr();
      fwd(1'($urandom), a, $urandom, 4'($urandom), md, $urandom_range(1, 6), $urandom);
    end
    cfg_read(2);

    // Upstream abort: master drops cyc mid-access; slave later errors
    slv_mode = 2; slv_delay = 5; slv_rdata = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0300; sel = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc = 0; stb = 0;
    saw_ack = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (wbm_ack_o) saw_ack = 1;
    end
    check("abort_no_ack", 32'(saw_ack), 32'd0);
    check("abort_stb_cycles", 32'(last_cycles), 32'd5);
    m_abort(1'b1);
    cfg_read(2);

    // Abort counter saturation
    for (int i = 0; i < 260; i++) fwd(1'b0, 32'h3000_0400, 32'h0, 4'hF, 2, 1, 32'h0);
    cfg_read(2);
    check("cnt_saturated", m_read(2) & 32'h0000_FF00, 32'h0000_FF00);

    // Reset asserted mid-forward
    cfg_write(0, 32'h55, 4'h1);
    slv_mode = 1; slv_delay = 1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0500; wdat = 32'h1; sel = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_wbs_cyc", 32'(wbs_cyc_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_wbs_cyc", 32'(wbs_cyc_o), 32'd0);
    check("midrst_soft", 32'(soft_rst_n_o), 32'd0);
    check("midrst_ack", 32'(wbm_ack_o), 32'd0);
    m_reset();
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_ack = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wbm_ack_o) saw_ack = 1;
    end
    check("post_rst_no_ack", 32'(saw_ack), 32'd0);
    cfg_read(0);
    cfg_read(2);
    fwd(1'b0, 32'h3000_0600, 32'h0, 4'hF, 0, 2, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
